// File: rtl/des_iter_dec_if.sv
// des_iter_dec_if: job-in / result-out valid-ready bundle for des_iter_dec.
// master = producer/consumer side, slave = the decrypt engine.
interface des_iter_dec_if;
    logic        inValid;
    logic        inReady;
    logic [63:0] cipherIn;
    logic [63:0] keyIn;
    logic        outValid;
    logic        outReady;
    logic [63:0] plainOut;
    logic        keyErr;

    modport master (
        output inValid, cipherIn, keyIn, outReady,
        input  inReady, outValid, plainOut, keyErr
    );

    modport slave (
        input  inValid, cipherIn, keyIn, outReady,
        output inReady, outValid, plainOut, keyErr
    );
endinterface

// File: rtl/des_iter_dec.sv
// des_iter_dec: iterative DES decryption, one Feistel round per clock.
// Accepts a job in IDLE, runs 16 rounds with the reversed key schedule,
// then holds the plaintext in DONE until the consumer takes it.
// Optional macro DES_DEC_PARITY_CHECK_EN: reject keys with a byte of even
// parity (result 0, keyErr=1, no rounds run).
module des_iter_dec (
    input  logic          clk,
    input  logic          rst,
    des_iter_dec_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Permutation tables hold DES bit numbers (1 = MSB of the source word).
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // S-box rows: entry [box*4 + row], column c is nibble c counted from the MSB.
    localparam logic [63:0] SBOX_T [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[32 - E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) y[31 - i] = x[32 - P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] sbox_all(input logic [47:0] x);
        logic [31:0]  y;
        logic [5:0]   six;
        logic [63:0]  ent;
        int unsigned  row;
        int unsigned  col;
        y = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            six = x[47 - 6 * b -: 6];
            row = 32'({six[5], six[0]});
            col = 32'(six[4:1]);
            ent = SBOX_T[b * 4 + row];
            y[31 - 4 * b -: 4] = ent[63 - 4 * col -: 4];
        end
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        return perm_p(sbox_all(perm_e(r) ^ k));
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [63:0] plain_q, plain_d;

    logic [63:0] ip_blk;
    logic [55:0] cd_ld;
    logic [47:0] round_key;
    logic [31:0] new_r;

`ifdef DES_DEC_PARITY_CHECK_EN
    logic key_err_q, key_err_d;

    function automatic logic key_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = 0; b < 8; b++) begin
            if (^k[8 * b +: 8] == 1'b0) ok = 1'b0;
        end
        return ok;
    endfunction
`else
    logic unused_key_parity;
    assign unused_key_parity = ^{bus.keyIn[56], bus.keyIn[48], bus.keyIn[40], bus.keyIn[32],
                                 bus.keyIn[24], bus.keyIn[16], bus.keyIn[8],  bus.keyIn[0]};
`endif

    // Next-state: job acceptance, one decrypt round per cycle, result hold.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        l_d       = l_q;
        r_d       = r_q;
        c_d       = c_q;
        d_d       = d_q;
        plain_d   = plain_q;
`ifdef DES_DEC_PARITY_CHECK_EN
        key_err_d = key_err_q;
`endif
        ip_blk    = perm_ip(bus.cipherIn);
        cd_ld     = perm_pc1(bus.keyIn);
        round_key = perm_pc2({c_q, d_q});
        new_r     = l_q ^ feistel(r_q, round_key);

        case (state_q)
            IDLE: begin
                if (bus.inValid) begin
                    l_d     = ip_blk[63:32];
                    r_d     = ip_blk[31:0];
                    c_d     = cd_ld[55:28];
                    d_d     = cd_ld[27:0];
                    rnd_d   = 5'd1;
                    state_d = ROUND;
`ifdef DES_DEC_PARITY_CHECK_EN
                    key_err_d = 1'b0;
                    if (!key_parity_ok(bus.keyIn)) begin
                        rnd_d     = '0;
                        plain_d   = '0;
                        key_err_d = 1'b1;
                        state_d   = DONE;
                    end
`endif
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = new_r;
                // The loaded C/D already give K16 (encrypt shifts sum to 28), so
                // decryption walks the schedule backwards with right rotations.
                if (rnd_q == 5'd1 || rnd_q == 5'd8 || rnd_q == 5'd15) begin
                    c_d = {c_q[0], c_q[27:1]};
                    d_d = {d_q[0], d_q[27:1]};
                end else begin
                    c_d = {c_q[1:0], c_q[27:2]};
                    d_d = {d_q[1:0], d_q[27:2]};
                end
                if (rnd_q == 5'd16) begin
                    plain_d = perm_fp({new_r, r_q});
                    rnd_d   = '0;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            DONE: begin
                if (bus.outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            plain_q   <= '0;
`ifdef DES_DEC_PARITY_CHECK_EN
            key_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            l_q       <= l_d;
            r_q       <= r_d;
            c_q       <= c_d;
            d_q       <= d_d;
            plain_q   <= plain_d;
`ifdef DES_DEC_PARITY_CHECK_EN
            key_err_q <= key_err_d;
`endif
        end
    end

    assign bus.inReady  = (state_q == IDLE);
    assign bus.outValid = (state_q == DONE);
    assign bus.plainOut = plain_q;
`ifdef DES_DEC_PARITY_CHECK_EN
    assign bus.keyErr   = key_err_q;
`else
    assign bus.keyErr   = 1'b0;
`endif

endmodule

// File: tb/tb_des_iter_dec.sv
// tb_des_iter_dec: directed-vector bench for des_iter_dec.
module tb_des_iter_dec;

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT_STD  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT_STD  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY_CB  = 64'h10316E028C8F3B4A;
    localparam logic [63:0] CT_CB   = 64'h82DCBAFBDEAB6602;
    localparam logic [63:0] PT_CB   = 64'h0000000000000000;
    localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    des_iter_dec_if bus();

    des_iter_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Drive one job and wait (bounded) for outValid. lat = edges after the
    // acceptance edge at which outValid is first seen.
    task automatic run_job(input logic [63:0] key, input logic [63:0] ct,
                           output int lat, output logic [63:0] pt, output logic err);
        bus.keyIn    = key;
        bus.cipherIn = ct;
        bus.inValid  = 1'b1;
        @(negedge clk);
        bus.inValid  = 1'b0;
        lat = 0;
        while (bus.outValid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pt  = bus.plainOut;
        err = bus.keyErr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b want 1", bus.inReady); end
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", bus.outValid); end
        checks++; if (bus.plainOut !== 64'h0) begin errors++; $display("FAIL reset_plainOut got %h want 0", bus.plainOut); end
        checks++; if (bus.keyErr !== 1'b0) begin errors++; $display("FAIL reset_keyErr got %b want 0", bus.keyErr); end
    endtask

    task automatic test_standard();
        int lat; logic [63:0] pt; logic err;
        bus.outReady = 1'b1;
        run_job(KEY_STD, CT_STD, lat, pt, err);
        checks++; if (lat !== 16) begin errors++; $display("FAIL std_latency got %0d want 16", lat); end
        checks++; if (pt !== PT_STD) begin errors++; $display("FAIL std_plain got %h want %h", pt, PT_STD); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL std_keyErr got %b want 0", err); end
        @(negedge clk);
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL std_done_one_cycle got %b want 0", bus.outValid); end
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL std_inReady_after got %b want 1", bus.inReady); end
    endtask

    task automatic test_codebase();
        int lat; logic [63:0] pt; logic err;
        bus.outReady = 1'b1;
        run_job(KEY_CB, CT_CB, lat, pt, err);
        checks++; if (lat !== 16) begin errors++; $display("FAIL cb_latency got %0d want 16", lat); end
        checks++; if (pt !== PT_CB) begin errors++; $display("FAIL cb_plain got %h want %h", pt, PT_CB); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cb_keyErr got %b want 0", err); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] pt; logic err;
        bus.outReady = 1'b0;
        run_job(KEY_STD, CT_STD, lat, pt, err);
        checks++; if (lat !== 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
        for (int i = 0; i < 10; i++) begin
            bus.inValid  = 1'b1;
            bus.cipherIn = ~bus.cipherIn ^ 64'(i);
            bus.keyIn    = ~bus.keyIn;
            @(negedge clk);
            checks++; if (bus.plainOut !== PT_STD) begin errors++; $display("FAIL bp_hold_plain[%0d] got %h want %h", i, bus.plainOut, PT_STD); end
            checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL bp_hold_inReady[%0d] got %b want 0", i, bus.inReady); end
            checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL bp_hold_outValid[%0d] got %b want 1", i, bus.outValid); end
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(negedge clk);
        checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL bp_release_outValid got %b want 0", bus.outValid); end
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL bp_release_inReady got %b want 1", bus.inReady); end
    endtask

    task automatic test_back_to_back();
        int edges; int lat; logic seen_ready; logic got_first; logic [63:0] first_pt;
        bus.outReady = 1'b1;
        bus.keyIn    = KEY_STD;
        bus.cipherIn = CT_STD;
        bus.inValid  = 1'b1;
        @(negedge clk);
        // Second job presented immediately; it must wait for the first to drain.
        bus.keyIn    = KEY_CB;
        bus.cipherIn = CT_CB;
        edges = 0; seen_ready = 1'b0; got_first = 1'b0; first_pt = '0;
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            if (bus.outValid === 1'b1 && !got_first) begin
                first_pt  = bus.plainOut;
                got_first = 1'b1;
            end
            if (bus.inReady === 1'b1) seen_ready = 1'b1;
            else if (seen_ready) break;
        end
        bus.inValid = 1'b0;
        checks++; if (edges !== 18) begin errors++; $display("FAIL b2b_accept_edge got %0d want 18", edges); end
        checks++; if (first_pt !== PT_STD) begin errors++; $display("FAIL b2b_first_plain got %h want %h", first_pt, PT_STD); end
        lat = 0;
        while (bus.outValid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_second_latency got %0d want 16", lat); end
        checks++; if (bus.plainOut !== PT_CB) begin errors++; $display("FAIL b2b_second_plain got %h want %h", bus.plainOut, PT_CB); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [63:0] pt; logic err;
        bus.outReady = 1'b1;
        bus.keyIn    = KEY_STD;
        bus.cipherIn = CT_STD;
        bus.inValid  = 1'b1;
        @(negedge clk);
        bus.inValid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL mid_rst_inReady got %b want 1", bus.inReady); end
        checks++; if (bus.plainOut !== 64'h0) begin errors++; $display("FAIL mid_rst_plain got %h want 0", bus.plainOut); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.outValid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_output got %0d valid cycles want 0", seen); end
        // Reset coinciding with a handshake discards the job.
        rst = 1'b1;
        bus.keyIn    = KEY_STD;
        bus.cipherIn = CT_STD;
        bus.inValid  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.inValid = 1'b0;
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL rst_vs_accept_inReady got %b want 1", bus.inReady); end
        run_job(KEY_STD, CT_STD, lat, pt, err);
        checks++; if (pt !== PT_STD) begin errors++; $display("FAIL mid_rst_next_plain got %h want %h", pt, PT_STD); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL mid_rst_next_latency got %0d want 16", lat); end
        @(negedge clk);
    endtask

    task automatic test_parity();
        int lat; logic [63:0] pt; logic err;
        bus.outReady = 1'b1;
        run_job(KEY_BAD, CT_STD, lat, pt, err);
`ifdef DES_DEC_PARITY_CHECK_EN
        // Rejected on the acceptance edge itself: DONE is visible the next cycle.
        checks++; if (lat !== 0) begin errors++; $display("FAIL par_latency got %0d want 0", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL par_keyErr got %b want 1", err); end
        checks++; if (pt !== 64'h0) begin errors++; $display("FAIL par_plain got %h want 0", pt); end
`else
        // Differs from KEY_STD only in a parity bit, so it decrypts identically.
        checks++; if (lat !== 16) begin errors++; $display("FAIL par_latency got %0d want 16", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL par_keyErr got %b want 0", err); end
        checks++; if (pt !== PT_STD) begin errors++; $display("FAIL par_plain got %h want %h", pt, PT_STD); end
`endif
        @(negedge clk);
        checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL par_inReady_after got %b want 1", bus.inReady); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.inValid  = 1'b0;
        bus.cipherIn = '0;
        bus.keyIn    = '0;
        bus.outReady = 1'b0;
        test_reset();
        test_standard();
        test_codebase();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_iter_dec.md
# des_iter_dec

Iterative DES decryption engine: accepts a 64-bit ciphertext block and a 64-bit parity-bearing key, runs the 16 Feistel rounds one per clock with the reversed key schedule, and returns the plaintext. It is the receive-side counterpart of the existing `des` encrypt path. Ciphertext produced by `des` with `decrypt=0` is recovered here. Handshaking is valid/ready on both sides so the block can sit between a block FIFO and a consumer.

## Interface
Parameters:
- none; FIPS 46-3 tables are fixed.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `inValid`  in  1  `cipherIn`/`keyIn` are valid.
- `inReady`  out  1  block can accept a new job.
- `cipherIn`  in  64  ciphertext; bit 63 is DES bit 1.
- `keyIn`  in  64  key with parity; bit 0 of each byte is parity; the 56 key bits are the other bits, packed MSB-first.
- `outValid`  out  1  `plainOut` is valid.
- `outReady`  in  1  consumer accepts `plainOut`.
- `plainOut`  out  64  plaintext; bit 63 is DES bit 1.
- `keyErr`  out  1  key parity failure for the current result; valid while `outValid=1`.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - `inReady=1`.
  - On `inValid&&inReady`, register L/R = IP(`cipherIn`) and C/D = PC1(`keyIn`).
  - Set round counter `rnd=1` and go to ROUND.
- ROUND:
  - One Feistel round per cycle: L'=R, R'=L xor f(R, PC2(C,D)).
  - Key schedule:
    - Round 1 uses C/D as loaded; this equals K16.
    - Before each of rounds 2..16, C and D are each rotated right by encrypt-shift[18−rnd].
    - Encrypt-shift table is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, indexed 1..16.
    - Right-rotate amounts over rounds 2..16 are therefore 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - f = P(S(E(R) xor K)). S-boxes S1..S8 per standard: row = outer bits, column = inner 4 bits.
  - After round 16, register `plainOut` = FP(R16‖L16) (halves swapped), set `outValid=1`, go to DONE.
- DONE:
  - `outValid=1`; `plainOut` and `keyErr` are held stable.
  - On `outReady=1`, deassert `outValid` and return to IDLE.
- `inReady` is 0 in ROUND and DONE. There is no overlap of jobs.
- Inputs are sampled only at acceptance. Changes to `cipherIn`/`keyIn` afterwards have no effect.

## Timing
- Reset values:
  - state=IDLE
  - `inReady=1`
  - `outValid=0`
  - `plainOut=64'h0`
  - `keyErr=0`
  - `rnd=0`
  - L/R/C/D=0
- Latency:
  - Acceptance at edge E0; rounds 1..16 execute on edges E1..E16.
  - `outValid` is high after E16, i.e. 16 cycles after acceptance.
- Throughput: back-to-back jobs need at least 18 cycles per block (accept, 16 rounds, 1 DONE cycle with `outReady=1`). `inReady` rises the cycle after the DONE handshake.
- `outReady` held high: DONE lasts exactly 1 cycle.
- `outReady` low: result held indefinitely; no new input is accepted.
- `inValid` while busy is ignored; the producer must hold it until `inReady`.
- Simultaneous `rst` and any handshake: reset wins. Job discarded, outputs return to reset values on that edge.
- Reset mid-ROUND: the partial result is never emitted.

## Configuration
- Macro: `DES_DEC_PARITY_CHECK_EN`.
- Defined:
  - At acceptance, each byte of `keyIn` is checked for odd parity.
  - Any failing byte sends the engine IDLE→DONE directly on the next edge, with `plainOut=64'h0` and `keyErr=1`. No rounds are run.
  - Good keys behave normally with `keyErr=0`.
- Undefined:
  - Parity bits are ignored and `keyErr` is tied to 0.
  - Every job takes the full 16-round path.

## Test plan
- Reset: assert `rst` 2 cycles -> `inReady=1`, `outValid=0`, `plainOut=0`, `keyErr=0`.
- Standard vector: key 133457799BBCDFF1, cipher 85E813540F0AB405, `outReady=1` -> `plainOut`=0123456789ABCDEF, `outValid` high exactly 16 cycles after acceptance for 1 cycle.
- Codebase vector: key 10316E028C8F3B4A, cipher 82DCBAFBDEAB6602 -> `plainOut`=0000000000000000, `keyErr=0`.
- Backpressure: `outReady=0` for 10 cycles after `outValid`, inputs toggled meanwhile -> `plainOut` stable, `inReady=0`. Raise `outReady` -> one handshake, then `inReady=1` next cycle. Next job accepted 18 cycles after the first.
- Reset mid-ROUND at round 8 -> `outValid` never asserts for that job. A following standard-vector job returns 0123456789ABCDEF.
- Parity (macro defined): key 123457799BBCDFF1 (byte 0x12 even) -> `outValid` 1 cycle after acceptance, `keyErr=1`, `plainOut=0`. With the macro undefined, the same key's result matches a software DES decrypt with the parity bits ignored, and `keyErr=0`.
